if_prefetch: RTL and testbench

//   Instruction prefetch stage that feeds the fetch FIFO. Generates sequential PCs, issues

---
 rtl/if_prefetch_if.sv | 37 +++
 rtl/if_prefetch.sv | 136 +++++++++++++
 tb/tb_if_prefetch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// Bundle of the prefetch stage's two buses: imem read port and the {pc, instr} packet stream.
// The master modport is the prefetch side; the slave modport is memory plus downstream FIFO.
interface if_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                             imem_req;
    logic [ADDR_WIDTH-1:0]            imem_addr;
    logic                             imem_gnt;
    logic                             imem_rvalid;
    logic [DATA_WIDTH-1:0]            imem_rdata;
    logic                             pf_tx_valid;
    logic                             pf_tx_ready;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] pf_tx_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output pf_tx_valid,
        input  pf_tx_ready,
        output pf_tx_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  pf_tx_valid,
        output pf_tx_ready,
        input  pf_tx_data
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch: sequential PC generation, credit-limited imem reads, redirect flush.
// Define PREFETCH_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt/perf_flush_cnt counters.
module if_prefetch #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
`ifdef PREFETCH_PERF_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt,
`endif
    if_prefetch_if.master         bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W:0]   MAX_CREDIT = (CNT_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      buf_count;
    logic [PTR_W-1:0]      buf_rd, buf_wr;
    logic [PTR_W-1:0]      pcq_rd, pcq_wr;
    logic [ADDR_WIDTH-1:0] pcq     [MAX_OUTSTANDING];
    logic [PKT_W-1:0]      pkt_buf [MAX_OUTSTANDING];

    logic credit_ok, req, granted, rsp, push, pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Discarded reads still hold credit, so inflight counts them until they return.
    assign credit_ok = ({1'b0, inflight} + {1'b0, buf_count}) < MAX_CREDIT;
    assign req       = (state == RUN) && !redirect_valid && credit_ok;
    assign granted   = req && bus.imem_gnt;
    assign rsp       = bus.imem_rvalid && (inflight != '0);
    assign push      = rsp && !redirect_valid && (discard == '0);
    assign pop       = (buf_count != '0) && bus.pf_tx_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.pf_tx_valid = (buf_count != '0);
    assign bus.pf_tx_data  = pkt_buf[buf_rd];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inflight  <= '0;
            discard   <= '0;
            buf_count <= '0;
            buf_rd    <= '0;
            buf_wr    <= '0;
            pcq_rd    <= '0;
            pcq_wr    <= '0;
        end else begin
            case (state)
                IDLE: if (fetch_en)  state <= RUN;
                RUN:  if (!fetch_en) state <= IDLE;
            endcase

            inflight <= inflight + CNT_W'(granted) - CNT_W'(rsp);

            if (redirect_valid) begin
                // Every read still unreturned after this edge belongs to the old stream.
                pc        <= redirect_pc & ~ADDR_WIDTH'(3);
                discard   <= inflight - CNT_W'(rsp);
                buf_count <= '0;
                buf_rd    <= '0;
                buf_wr    <= '0;
                pcq_rd    <= '0;
                pcq_wr    <= '0;
            end else begin
                if (granted) begin
                    pc     <= pc + ADDR_WIDTH'(4);
                    pcq_wr <= ptr_next(pcq_wr);
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    buf_wr <= ptr_next(buf_wr);
                    pcq_rd <= ptr_next(pcq_rd);
                end
                if (pop) begin
                    buf_rd <= ptr_next(buf_rd);
                end
                buf_count <= buf_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (granted) begin
            pcq[pcq_wr] <= pc;
        end
        if (push) begin
            pkt_buf[buf_wr] <= {pcq[pcq_rd], bus.imem_rdata};
        end
    end

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (req && !bus.imem_gnt) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a queue-level model of reads and packets is compared
// against the DUT every cycle, and literal expectations pin the model at key points.
module tb_if_prefetch;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          MAXO = 2;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk            = 1'b0;
    logic        rstn           = 1'b1;
    logic        fetch_en       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    if_prefetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    if_prefetch #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC       (RPC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
`ifdef PREFETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] pc;
        bit          drop;
    } rd_t;

    rd_t         m_out[$];
    logic [63:0] m_buf[$];
    logic [63:0] m_log[$];
    bit          m_run   = 1'b0;
    logic [31:0] m_pc    = RPC;
    int unsigned m_fetch = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    logic [31:0] pending[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkLog(input string name, input int idx, input logic [63:0] expected, input bit full_pkt);
        if (idx < m_log.size()) begin
            if (full_pkt) checkOutput(name, m_log[idx], expected);
            else          checkOutput(name, {32'h0, m_log[idx][63:32]}, {32'h0, expected[31:0]});
        end else begin
            checks++;
            fails++;
            $display("[TB] FAIL %s: actual=no packet required=%h", name, expected);
        end
    endtask

    // Drives one input pattern for n cycles; a tiny memory returns each granted read next cycle.
    task automatic applyStimulus(input int n, input bit fe, input bit g, input bit rsp, input bit rdy,
                                 input bit redir, input logic [31:0] rpc,
                                 input bit stray = 1'b0, input bit rst = 1'b0);
        for (int i = 0; i < n; i++) begin
            rstn = !rst;
            if (rst) pending.delete();
            fetch_en        = fe;
            redirect_valid  = redir;
            redirect_pc     = rpc;
            bus.imem_gnt    = g;
            bus.pf_tx_ready = rdy;
            if (rsp && pending.size() > 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pending.pop_front());
            end else if (stray) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = $urandom;
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end
            #1;
            if (rstn && bus.imem_req && bus.imem_gnt) pending.push_back(bus.imem_addr);
            @(negedge clk);
            #1;
        end
    endtask

    // Compare process: check DUT against the model, then advance the model over the next edge.
    initial begin
        bit  exp_req, exp_valid, granted, rsp, pop;
        rd_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                m_out.delete();
                m_buf.delete();
                m_run   = 1'b0;
                m_pc    = RPC;
                m_fetch = 0;
                m_stall = 0;
                m_flush = 0;
                checkOutput("reset_req", bus.imem_req, 1'b0);
                checkOutput("reset_valid", bus.pf_tx_valid, 1'b0);
`ifdef PREFETCH_PERF_EN
                checkOutput("reset_perf", {perf_fetch_cnt, perf_stall_cnt | perf_flush_cnt}, 64'h0);
`endif
            end else begin
                exp_req   = m_run && !redirect_valid && (m_out.size() + m_buf.size() < MAXO);
                exp_valid = (m_buf.size() != 0);
                checkOutput("imem_req", bus.imem_req, exp_req);
                if (exp_req) checkOutput("imem_addr", bus.imem_addr, m_pc);
                checkOutput("pf_tx_valid", bus.pf_tx_valid, exp_valid);
                if (exp_valid) checkOutput("pf_tx_data", bus.pf_tx_data, m_buf[0]);
`ifdef PREFETCH_PERF_EN
                checkOutput("perf_fetch", perf_fetch_cnt, m_fetch);
                checkOutput("perf_stall", perf_stall_cnt, m_stall);
                checkOutput("perf_flush", perf_flush_cnt, m_flush);
`endif
                granted = exp_req && bus.imem_gnt;
                rsp     = bus.imem_rvalid && (m_out.size() > 0);
                pop     = exp_valid && bus.pf_tx_ready;
                m_run   = fetch_en;
                if (exp_req && !bus.imem_gnt) m_stall++;
                if (redirect_valid) m_flush++;
                if (pop) begin
                    m_fetch++;
                    m_log.push_back(m_buf.pop_front());
                end
                if (redirect_valid) begin
                    if (rsp) void'(m_out.pop_front());
                    foreach (m_out[k]) m_out[k].drop = 1'b1;
                    m_buf.delete();
                    m_pc = redirect_pc & ~32'h3;
                end else begin
                    if (rsp) begin
                        r = m_out.pop_front();
                        if (!r.drop) m_buf.push_back({r.pc, bus.imem_rdata});
                    end
                    if (granted) begin
                        m_out.push_back('{pc: m_pc, drop: 1'b0});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    initial begin
        int          mark;
        int unsigned s0;
`ifdef PREFETCH_PERF_EN
        logic [31:0] p0;
`endif
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.pf_tx_ready = 1'b0;
        @(negedge clk);
        #1;

        $display("[TB] reset then sustained sequential fetch");
        applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(20, 1, 1, 1, 1, 0, 0);
        checkLog("seq_pkt0", 0, 64'h0000_0000_CAFE_0000, 1);
        checkLog("seq_pkt1", 1, 64'h0000_0004_CAFE_0004, 1);
        checkLog("seq_pkt3_pc", 3, 64'h0000_000C, 0);

        $display("[TB] downstream backpressure");
        applyStimulus(10, 1, 1, 1, 0, 0, 0);
        applyStimulus(8, 1, 1, 1, 1, 0, 0);

        $display("[TB] redirect with two reads in flight");
        applyStimulus(6, 0, 0, 1, 1, 0, 0);
        applyStimulus(4, 1, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 1, 32'h100);
        mark = m_log.size();
        applyStimulus(10, 1, 1, 1, 1, 0, 0);
        checkLog("redir_first_pc", mark, 64'h100, 0);
        checkLog("redir_first_pkt", mark, 64'h0000_0100_CAFE_0100, 1);

        $display("[TB] redirect coinciding with gnt and rvalid, unaligned target");
        applyStimulus(3, 1, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 1, 32'h102);
        mark = m_log.size();
        applyStimulus(10, 1, 1, 1, 1, 0, 0);
        checkLog("redir_unaligned_pc", mark, 64'h100, 0);

        $display("[TB] grant withheld for five cycles");
        applyStimulus(6, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 0, 0);
        s0 = m_stall;
`ifdef PREFETCH_PERF_EN
        p0 = perf_stall_cnt;
`endif
        applyStimulus(5, 1, 0, 1, 1, 0, 0);
        checkOutput("stall_cycles_model", 64'(m_stall - s0), 64'd5);
`ifdef PREFETCH_PERF_EN
        checkOutput("perf_stall_delta", perf_stall_cnt - p0, 32'd5);
`endif
        applyStimulus(6, 1, 1, 1, 1, 0, 0);

        $display("[TB] reset mid-transaction and stray rvalid");
        applyStimulus(6, 1, 1, 1, 0, 0, 0);
        applyStimulus(2, 1, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus(2, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("stray_no_push", bus.pf_tx_valid, 1'b0);
        mark = m_log.size();
        applyStimulus(10, 1, 1, 1, 1, 0, 0);
        checkLog("restart_pc", mark, 64'(RPC), 0);

        $display("[TB] back-to-back redirects");
        applyStimulus(1, 1, 1, 1, 1, 1, 32'h200);
        applyStimulus(1, 1, 1, 1, 1, 1, 32'h300);
        mark = m_log.size();
        applyStimulus(10, 1, 1, 1, 1, 0, 0);
        checkLog("b2b_redir_pc", mark, 64'h300, 0);

        $display("[TB] pc wrap at top of address space");
        applyStimulus(1, 1, 1, 1, 1, 1, 32'hFFFF_FFFC);
        mark = m_log.size();
        applyStimulus(10, 1, 1, 1, 1, 0, 0);
        checkLog("wrap_pc_top", mark, 64'hFFFF_FFFC, 0);
        checkLog("wrap_pkt_zero", mark + 1, 64'h0000_0000_CAFE_0000, 1);

        $display("[TB] fetch disabled with reads in flight");
        applyStimulus(8, 0, 1, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
